pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Pipeline stall/flush sequencer for the 5-stage core. It sits beside the hazard unit and owns every per-stage enable and bubble signal. It resolves load-use hazards, taken-branch flushes, variable-latency data-memory waits and the fixed-latency divider, and it keeps a stall-cycle performance counter. Forwarding stays in the hazard unit; this block only decides which stages freeze or bubble each cycle.

## Interface
Parameters:
- DIV_LATENCY, 32, cycles the divider occupies E; must be ≥ 2.
- MEM_TIMEOUT, 255, consecutive memory-wait cycles before `mem_err` sets.
- CNT_W, 32, width of `stall_cycles`.

Ports:
- clk  in  1  core clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- rs1_d, rs2_d  in  5 each  source registers of the instruction in D.
- rd_e  in  5  destination register of the instruction in E.
- mem_read_e  in  1  instruction in E is a load.
- branch_e  in  1  taken branch or jump resolved in E.
- div_start_e  in  1  divide instruction present in E, first cycle.
- mem_req_m  in  1  M-stage access in flight.
- mem_ready  in  1  data memory completes the access this cycle.
- stall_f, stall_d, stall_e, stall_m  out  1 each  hold the stage register.
- flush_d, flush_e, flush_m, flush_w  out  1 each  load a bubble into the stage register.
- div_done  out  1  divider result is valid; E may advance.
- mem_err  out  1  sticky memory timeout flag.
- stall_cycles  out  CNT_W  count of cycles with `stall_f` = 1.

## Operation
- **Memory stall** (`ms`) = `mem_req_m & ~mem_ready`. It asserts `stall_f`, `stall_d`, `stall_e` and `stall_m`, plus `flush_w`. It has highest priority.
- **FSM states:** RUN, DIV_BUSY, DIV_HOLD.
  - **RUN → DIV_BUSY** on `div_start_e & ~ms`. Load `div_cnt` = DIV_LATENCY-1. That cycle asserts `stall_f`, `stall_d`, `stall_e` and `flush_m`.
  - **DIV_BUSY, `div_cnt` ≠ 0:** assert `stall_f`, `stall_d`, `stall_e` and `flush_m`, then decrement. The counter also decrements during `ms`.
  - **DIV_BUSY, `div_cnt` = 0:**
    - If `ms` = 0: assert `div_done`, release all stalls, go to RUN.
    - Otherwise go to DIV_HOLD.
  - **DIV_HOLD:** hold stalls until `ms` = 0. In that cycle assert `div_done`, then go to RUN.
- **Load-use hazard:** `mem_read_e` & (`rd_e` ≠ 0) & (`rd_e` = `rs1_d` | `rd_e` = `rs2_d`). It asserts `stall_f`, `stall_d` and `flush_e`. It is evaluated only in RUN with `ms` = 0.
- **Branch:** `branch_e` asserts `flush_d` and `flush_e`. It is honoured only when `stall_e` = 0. A stalled branch re-presents itself next cycle.
- **Branch vs. load-use in the same cycle:** branch wins. Suppress the load-use stall, because D is being flushed.
- **Flush masking:** `flush_e` is never asserted while `stall_e` = 1. Load-use and branch are both masked when E is frozen.
- **Memory watchdog:**
  - `mem_wait` counter increments while `ms`, saturates at MEM_TIMEOUT, and clears when `ms` = 0.
  - Reaching MEM_TIMEOUT sets `mem_err`, which stays set until `rst`.
  - Stalling continues after the timeout.
- **`stall_cycles`:** +1 every cycle `stall_f` = 1; wraps modulo 2^CNT_W.

## Timing
- Stall and flush outputs are combinational from state and inputs, valid in the same cycle. `stall_cycles` and `mem_err` are registered.
- **Divider:** `div_start_e` at cycle T with no `ms` gives stalls in T..T+DIV_LATENCY-1 and `div_done` at T+DIV_LATENCY. E advances at the following edge.
- **Memory:** `ms` in cycles T..T+k-1 gives exactly k frozen cycles. `mem_ready` at T+k releases in the same cycle.
- **During `rst`:**
  - All stall outputs are 0.
  - `flush_d`, `flush_e`, `flush_m` and `flush_w` are all 1.
  - `div_done` = 0.
- **After `rst`:**
  - State is RUN, with `div_cnt` = 0 and `mem_wait` = 0.
  - `mem_err` = 0 and `stall_cycles` = 0.
  - Reset mid-divide abandons the operation.
- `div_start_e` outside RUN is ignored.

## Structure
- `pipeline_ctrl_pkg` holds:
  - the `ctrl_state_t` enum (RUN, DIV_BUSY, DIV_HOLD);
  - `DIV_CNT_W` = $clog2(DIV_LATENCY);
  - `MEM_CNT_W` = $clog2(MEM_TIMEOUT+1);
  - stage-index constants.
- One sub-module, `sat_counter`: a saturating, clearable up-counter with a terminal flag, used for the memory watchdog.
- The divider down-counter and the FSM live in the top module.

## Test plan
- **Load-use:** `mem_read_e` = 1, `rd_e` = 5, `rs2_d` = 5 → one cycle of `stall_f`, `stall_d`, `flush_e`. With `rd_e` = 0 → no stall.
- **Divider:** `div_start_e` at T, DIV_LATENCY = 4 → stalls in T..T+3, `div_done` = 1 at T+4 only, `stall_cycles` += 4.
- **Memory wait:** `mem_req_m` = 1 with `mem_ready` low for 3 cycles → all four stalls plus `flush_w` for exactly 3 cycles. With MEM_TIMEOUT = 2, `mem_err` sets and stays 1 until `rst`.
- **Overlap:** `ms` covers the divider's terminal cycle → DIV_HOLD entered; `div_done` is delayed to the first cycle with `ms` = 0, with no extra or missing stall cycles.
- **Branch masking:**
  - `branch_e` during DIV_BUSY → no flush.
  - `branch_e` in RUN together with a load-use hazard → `flush_d` = `flush_e` = 1 and `stall_f` = 0.
- **Reset mid-divide:** `rst` at `div_cnt` = 10 → next cycle in RUN, all stalls 0, `div_done` never asserted, `stall_cycles` = 0.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
// Holds the FSM encoding, counter widths and pipeline stage indices.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_HOLD = 2'd2
    } ctrl_state_t;

    localparam int DIV_LATENCY_DEF = 32;
    localparam int MEM_TIMEOUT_DEF = 255;
    localparam int DIV_CNT_W       = $clog2(DIV_LATENCY_DEF);
    localparam int MEM_CNT_W       = $clog2(MEM_TIMEOUT_DEF + 1);

    localparam int STAGE_F = 0;
    localparam int STAGE_D = 1;
    localparam int STAGE_E = 2;
    localparam int STAGE_M = 3;
    localparam int STAGE_W = 4;

    // Width helpers for instances that override the default latencies.
    function automatic int div_cnt_width(input int latency);
        return $clog2(latency);
    endfunction

    function automatic int mem_cnt_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating, clearable up-counter with a terminal flag; used as the
// memory-wait watchdog.
module sat_counter #(
    parameter int W   = 8,
    parameter int MAX = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clear,
    output logic terminal
);

    logic [W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (inc && (count != W'(MAX))) begin
            count <= count + W'(1);
        end
    end

    assign terminal = (count == W'(MAX));

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush sequencer: decides per cycle which stages freeze or
// take a bubble for memory waits, the fixed-latency divider, load-use and branches.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int DIV_LATENCY = 32,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1_d,
    input  logic [4:0]       rs2_d,
    input  logic [4:0]       rd_e,
    input  logic             mem_read_e,
    input  logic             branch_e,
    input  logic             div_start_e,
    input  logic             mem_req_m,
    input  logic             mem_ready,
    output logic             stall_f,
    output logic             stall_d,
    output logic             stall_e,
    output logic             stall_m,
    output logic             flush_d,
    output logic             flush_e,
    output logic             flush_m,
    output logic             flush_w,
    output logic             div_done,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int DCW = div_cnt_width(DIV_LATENCY);
    localparam int MCW = mem_cnt_width(MEM_TIMEOUT);
    localparam logic [DCW-1:0] DIV_LOAD = DCW'(DIV_LATENCY - 1);

    ctrl_state_t state, state_next;
    logic [DCW-1:0] div_cnt, div_cnt_next;
    logic ms, load_use, mem_timeout, div_done_c;
    logic [STAGE_M:STAGE_F] stall_v;
    logic [STAGE_W:STAGE_D] flush_v;

    assign ms       = mem_req_m & ~mem_ready;
    assign load_use = mem_read_e & (rd_e != 5'd0) & ((rd_e == rs1_d) | (rd_e == rs2_d));

    // NOTE: every signal written here gets a default first, so no path
    // through the block can leave one unassigned and infer a latch.
    always_comb begin
        state_next   = state;
        div_cnt_next = div_cnt;
        stall_v      = '0;
        flush_v      = '0;
        div_done_c   = 1'b0;

        if (ms) begin
            stall_v          = '1;
            flush_v[STAGE_W] = 1'b1;
        end

        unique case (state)
            RUN: begin
                if (div_start_e && !ms) begin
                    stall_v[STAGE_E:STAGE_F] = '1;
                    flush_v[STAGE_M]         = 1'b1;
                    div_cnt_next             = DIV_LOAD;
                    state_next               = DIV_BUSY;
                end
            end
            DIV_BUSY: begin
                if (div_cnt != '0) begin
                    // M is frozen during a memory wait, so it must not take a bubble.
                    stall_v[STAGE_E:STAGE_F] = '1;
                    flush_v[STAGE_M]         = ~ms;
                    div_cnt_next             = div_cnt - DCW'(1);
                end else if (!ms) begin
                    div_done_c = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = DIV_HOLD;
                end
            end
            DIV_HOLD: begin
                if (!ms) begin
                    div_done_c = 1'b1;
                    state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase

        // A frozen E masks both flush sources; a branch flushes D, so it
        // overrides the load-use stall.
        if (!stall_v[STAGE_E]) begin
            if (branch_e) begin
                flush_v[STAGE_E:STAGE_D] = '1;
            end else if ((state == RUN) && load_use) begin
                stall_v[STAGE_D:STAGE_F] = '1;
                flush_v[STAGE_E]         = 1'b1;
            end
        end

        if (rst) begin
            stall_v    = '0;
            flush_v    = '1;
            div_done_c = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RUN;
            div_cnt <= '0;
        end else begin
            state   <= state_next;
            div_cnt <= div_cnt_next;
        end
    end

    sat_counter #(
        .W   (MCW),
        .MAX (MEM_TIMEOUT)
    ) u_mem_wait (
        .clk      (clk),
        .rst      (rst),
        .inc      (ms),
        .clear    (~ms),
        .terminal (mem_timeout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_err      <= 1'b0;
            stall_cycles <= '0;
        end else begin
            if (mem_timeout) mem_err <= 1'b1;
            if (stall_v[STAGE_F]) stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

    assign stall_f  = stall_v[STAGE_F];
    assign stall_d  = stall_v[STAGE_D];
    assign stall_e  = stall_v[STAGE_E];
    assign stall_m  = stall_v[STAGE_M];
    assign flush_d  = flush_v[STAGE_D];
    assign flush_e  = flush_v[STAGE_E];
    assign flush_m  = flush_v[STAGE_M];
    assign flush_w  = flush_v[STAGE_W];
    assign div_done = div_done_c;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed testbench for pipeline_ctrl with DIV_LATENCY=4 and MEM_TIMEOUT=2.
// Output vector order: {stall_f,stall_d,stall_e,stall_m,flush_d,flush_e,flush_m,flush_w,div_done}.
module tb_pipeline_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs1_d, rs2_d, rd_e;
    logic        mem_read_e, branch_e, div_start_e, mem_req_m, mem_ready;
    logic        stall_f, stall_d, stall_e, stall_m;
    logic        flush_d, flush_e, flush_m, flush_w;
    logic        div_done, mem_err;
    logic [31:0] stall_cycles;
    logic [8:0]  obs;
    logic [31:0] exp_sc;

    int errors = 0;
    int checks = 0;

    localparam logic [8:0] V_IDLE = 9'b000000000;
    localparam logic [8:0] V_LU   = 9'b110001000;
    localparam logic [8:0] V_BR   = 9'b000011000;
    localparam logic [8:0] V_DIV  = 9'b111000100;
    localparam logic [8:0] V_MS   = 9'b111100010;
    localparam logic [8:0] V_DONE = 9'b000000001;
    localparam logic [8:0] V_RST  = 9'b000011110;

    pipeline_ctrl #(
        .DIV_LATENCY (4),
        .MEM_TIMEOUT (2),
        .CNT_W       (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rs1_d        (rs1_d),
        .rs2_d        (rs2_d),
        .rd_e         (rd_e),
        .mem_read_e   (mem_read_e),
        .branch_e     (branch_e),
        .div_start_e  (div_start_e),
        .mem_req_m    (mem_req_m),
        .mem_ready    (mem_ready),
        .stall_f      (stall_f),
        .stall_d      (stall_d),
        .stall_e      (stall_e),
        .stall_m      (stall_m),
        .flush_d      (flush_d),
        .flush_e      (flush_e),
        .flush_m      (flush_m),
        .flush_w      (flush_w),
        .div_done     (div_done),
        .mem_err      (mem_err),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    assign obs = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, flush_w, div_done};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic idle();
        rs1_d = 5'd0; rs2_d = 5'd0; rd_e = 5'd0;
        mem_read_e = 1'b0; branch_e = 1'b0; div_start_e = 1'b0;
        mem_req_m = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        cyc();
        @(negedge clk);
        checks++;
        if (obs !== V_RST) begin
            errors++; $display("FAIL reset_outputs: got %b expected %b", obs, V_RST);
        end
        checks++;
        if (stall_cycles !== 32'd0 || mem_err !== 1'b0) begin
            errors++; $display("FAIL reset_regs: got sc=%0d err=%b expected 0/0", stall_cycles, mem_err);
        end
        cyc();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== V_IDLE) begin
            errors++; $display("FAIL post_reset_idle: got %b expected %b", obs, V_IDLE);
        end
        cyc();
        exp_sc = 32'd0;
    endtask

    task automatic test_load_use();
        idle();
        mem_read_e = 1'b1; rd_e = 5'd5; rs1_d = 5'd3; rs2_d = 5'd5;
        @(negedge clk);
        checks++;
        if (obs !== V_LU) begin
            errors++; $display("FAIL lu_rs2: got %b expected %b", obs, V_LU);
        end
        cyc();
        rd_e = 5'd0; rs1_d = 5'd0; rs2_d = 5'd0;
        @(negedge clk);
        checks++;
        if (obs !== V_IDLE) begin
            errors++; $display("FAIL lu_rd_zero: got %b expected %b", obs, V_IDLE);
        end
        cyc();
        rd_e = 5'd7; rs1_d = 5'd7; rs2_d = 5'd1;
        @(negedge clk);
        checks++;
        if (obs !== V_LU) begin
            errors++; $display("FAIL lu_rs1: got %b expected %b", obs, V_LU);
        end
        cyc();
        mem_read_e = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== V_IDLE) begin
            errors++; $display("FAIL lu_no_load: got %b expected %b", obs, V_IDLE);
        end
        cyc();
        exp_sc = exp_sc + 32'd2;
        checks++;
        if (stall_cycles !== exp_sc) begin
            errors++; $display("FAIL lu_stall_count: got %0d expected %0d", stall_cycles, exp_sc);
        end
    endtask

    task automatic test_branch();
        idle();
        branch_e = 1'b1; mem_read_e = 1'b1; rd_e = 5'd9; rs1_d = 5'd9;
        @(negedge clk);
        checks++;
        if (obs !== V_BR) begin
            errors++; $display("FAIL branch_vs_lu: got %b expected %b", obs, V_BR);
        end
        cyc();
        mem_read_e = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== V_BR) begin
            errors++; $display("FAIL branch_alone: got %b expected %b", obs, V_BR);
        end
        cyc();
        idle();
        checks++;
        if (stall_cycles !== exp_sc) begin
            errors++; $display("FAIL branch_stall_count: got %0d expected %0d", stall_cycles, exp_sc);
        end
    endtask

    task automatic test_divider();
        idle();
        div_start_e = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== V_DIV) begin
            errors++; $display("FAIL div_start: got %b expected %b", obs, V_DIV);
        end
        cyc();
        for (int i = 1; i <= 3; i++) begin
            div_start_e = (i == 1);
            branch_e    = (i == 2);
            @(negedge clk);
            checks++;
            if (obs !== V_DIV) begin
                errors++; $display("FAIL div_busy_%0d: got %b expected %b", i, obs, V_DIV);
            end
            cyc();
        end
        idle();
        @(negedge clk);
        checks++;
        if (obs !== V_DONE) begin
            errors++; $display("FAIL div_done: got %b expected %b", obs, V_DONE);
        end
        cyc();
        @(negedge clk);
        checks++;
        if (obs !== V_IDLE) begin
            errors++; $display("FAIL div_after: got %b expected %b", obs, V_IDLE);
        end
        exp_sc = exp_sc + 32'd4;
        checks++;
        if (stall_cycles !== exp_sc) begin
            errors++; $display("FAIL div_stall_count: got %0d expected %0d", stall_cycles, exp_sc);
        end
        cyc();
    endtask

    task automatic test_mem_wait();
        idle();
        mem_req_m = 1'b1; mem_ready = 1'b0;
        mem_read_e = 1'b1; rd_e = 5'd5; rs2_d = 5'd5;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== V_MS) begin
                errors++; $display("FAIL mem_wait_%0d: got %b expected %b", i, obs, V_MS);
            end
            if (i == 2) begin
                checks++;
                if (mem_err !== 1'b0) begin
                    errors++; $display("FAIL mem_err_early: got %b expected 0", mem_err);
                end
            end
            cyc();
        end
        idle();
        mem_req_m = 1'b1; mem_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== V_IDLE) begin
            errors++; $display("FAIL mem_release: got %b expected %b", obs, V_IDLE);
        end
        cyc();
        idle();
        cyc();
        cyc();
        checks++;
        if (mem_err !== 1'b1) begin
            errors++; $display("FAIL mem_err_sticky: got %b expected 1", mem_err);
        end
        exp_sc = exp_sc + 32'd3;
        checks++;
        if (stall_cycles !== exp_sc) begin
            errors++; $display("FAIL mem_stall_count: got %0d expected %0d", stall_cycles, exp_sc);
        end
    endtask

    task automatic test_overlap();
        logic [8:0] exp_seq [0:6];
        exp_seq = '{V_DIV, V_DIV, V_MS, V_DIV, V_MS, V_MS, V_DONE};
        idle();
        for (int i = 0; i < 7; i++) begin
            div_start_e = (i == 0);
            mem_req_m   = (i == 2) || (i >= 4);
            mem_ready   = (i == 6);
            @(negedge clk);
            checks++;
            if (obs !== exp_seq[i]) begin
                errors++; $display("FAIL overlap_%0d: got %b expected %b", i, obs, exp_seq[i]);
            end
            cyc();
        end
        idle();
        @(negedge clk);
        checks++;
        if (obs !== V_IDLE) begin
            errors++; $display("FAIL overlap_after: got %b expected %b", obs, V_IDLE);
        end
        exp_sc = exp_sc + 32'd6;
        checks++;
        if (stall_cycles !== exp_sc || mem_err !== 1'b1) begin
            errors++; $display("FAIL overlap_regs: got sc=%0d err=%b expected sc=%0d err=1",
                               stall_cycles, mem_err, exp_sc);
        end
        cyc();
    endtask

    task automatic test_reset_mid_div();
        idle();
        div_start_e = 1'b1;
        cyc();
        div_start_e = 1'b0;
        cyc();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== V_RST) begin
            errors++; $display("FAIL rst_mid_div: got %b expected %b", obs, V_RST);
        end
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== V_IDLE) begin
                errors++; $display("FAIL rst_abandon_%0d: got %b expected %b", i, obs, V_IDLE);
            end
            cyc();
        end
        checks++;
        if (stall_cycles !== 32'd0 || mem_err !== 1'b0) begin
            errors++; $display("FAIL rst_mid_div_regs: got sc=%0d err=%b expected 0/0", stall_cycles, mem_err);
        end
    endtask

    initial begin
        exp_sc = 32'd0;
        test_reset();
        test_load_use();
        test_branch();
        test_divider();
        test_mem_wait();
        test_overlap();
        test_reset_mid_div();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
